// File: rtl/motor_pkg.sv
// Shared types for the motor command sequencer: direction codes, per-channel drive
// direction, frame FSM states and the frame header/checksum helpers.
package motor_pkg;

  typedef enum logic [2:0] {
    DC_STOP  = 3'b000,
    DC_FWD   = 3'b001,
    DC_LEFT  = 3'b010,
    DC_REV   = 3'b011,
    DC_RIGHT = 3'b100
  } dir_cmd_t;

  typedef enum logic [1:0] {
    COAST = 2'b00,
    FWD   = 2'b01,
    REV   = 2'b10
  } motor_dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_B0,
    ST_SEND_B1,
    ST_SEND_B2,
    ST_SEND_B3,
    ST_NEXT_CH,
    ST_DONE
  } frame_state_t;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  function automatic logic [7:0] checksum(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser, LSB first, idle high; 10*CLKS_PER_BIT cycles per byte.
// A start accepted in the done cycle chains the next byte with no idle bits; other starts while busy are dropped.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic          active_q, active_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign done    = active_q && bit_end && (bit_q == 4'd9);
  assign tx      = active_q ? shift_q[0] : 1'b1;

  always_comb begin
    active_d = active_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    if (active_q) begin
      if (bit_end) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = {1'b1, shift_q[9:1]};
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (start && (!active_q || done)) begin
      active_d = 1'b1;
      shift_d  = {1'b1, data, 1'b0};
      bit_d    = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      shift_q  <= '1;
      bit_q    <= '0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Slew-limited multi-channel motor sequencer emitting checksummed 4-byte UART frames per channel.
// Command-to-start-bit within RAMP_CYCLES+3 cycles; extra triggers during a burst collapse into one follow-up burst.
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int NUM_MOTORS     = 2,
  parameter int SPEED_W        = 3,
  parameter int CLKS_PER_BIT   = 434,
  parameter int RAMP_CYCLES    = 2500000,
  parameter int REFRESH_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_dir,
  input  logic [SPEED_W-1:0] cmd_speed,
  input  logic               estop,
  output logic               uart_out,
  output logic               busy,
  output logic               burst_done,
  output logic               ramping
);

  localparam int CHW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam int RMW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam int RFW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [RMW-1:0] ramp_q, ramp_d;
  logic           ramp_tick;
  logic [RFW-1:0] ref_q, ref_d;
  logic           ref_hit;
  logic           estop_q, estop_rise;

  logic [NUM_MOTORS-1:0][1:0]         cur_dir_v;
  logic [NUM_MOTORS-1:0][SPEED_W-1:0] cur_spd_v;
  logic [NUM_MOTORS-1:0]              chg_v, diff_v;
  logic                               trig;

  frame_state_t       state_q, state_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic               pend_q, pend_d, abort_q, abort_d;
  motor_dir_t         snap_dir_q, snap_dir_d;
  logic [SPEED_W-1:0] snap_spd_q, snap_spd_d;
  logic               burst_start, tx_start, tx_done, tx_line;
  logic [7:0]         tx_data, b1, b2, b3;

  assign ramp_tick  = (ramp_q == RMW'(RAMP_CYCLES - 1));
  assign ramp_d     = ramp_tick ? '0 : ramp_q + RMW'(1);
  assign ref_hit    = (ref_q == RFW'(REFRESH_CYCLES - 1));
  assign ref_d      = burst_start ? '0 : (ref_hit ? ref_q : ref_q + RFW'(1));
  assign estop_rise = estop && !estop_q;

  // estop clears every channel in one step; that change is reported through the
  // estop edge so it never lands in the pending flag.
  assign trig    = (!estop && (|chg_v)) || ref_hit;
  assign ramping = |diff_v;

  for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_ch
    motor_dir_t         tgt_dir_q, tgt_dir_d, cur_dir_q, cur_dir_d, run_dir;
    logic [SPEED_W-1:0] tgt_spd_q, tgt_spd_d, cur_spd_q, cur_spd_d;

    always_comb begin
      case (cmd_dir)
        DC_FWD:   run_dir = FWD;
        DC_REV:   run_dir = REV;
        DC_LEFT:  run_dir = (i % 2 == 0) ? REV : FWD;
        DC_RIGHT: run_dir = (i % 2 == 0) ? FWD : REV;
        default:  run_dir = COAST;
      endcase

      // A zero-speed target is always stored as COAST so the ramp can settle.
      tgt_dir_d = tgt_dir_q;
      tgt_spd_d = tgt_spd_q;
      if (estop) begin
        tgt_dir_d = COAST;
        tgt_spd_d = '0;
      end else if (cmd_valid) begin
        if (run_dir == COAST || cmd_speed == '0) begin
          tgt_dir_d = COAST;
          tgt_spd_d = '0;
        end else begin
          tgt_dir_d = run_dir;
          tgt_spd_d = cmd_speed;
        end
      end

      cur_dir_d = cur_dir_q;
      cur_spd_d = cur_spd_q;
      if (estop) begin
        cur_dir_d = COAST;
        cur_spd_d = '0;
      end else if (ramp_tick) begin
        if (cur_dir_q != tgt_dir_q && cur_spd_q != '0) begin
          cur_spd_d = cur_spd_q - SPEED_W'(1);
          if (cur_spd_q == SPEED_W'(1)) cur_dir_d = COAST;
        end else if (cur_spd_q == '0) begin
          if (tgt_spd_q != '0) begin
            cur_dir_d = tgt_dir_q;
            cur_spd_d = SPEED_W'(1);
          end else begin
            cur_dir_d = COAST;
          end
        end else if (cur_spd_q < tgt_spd_q) begin
          cur_spd_d = cur_spd_q + SPEED_W'(1);
        end else if (cur_spd_q > tgt_spd_q) begin
          cur_spd_d = cur_spd_q - SPEED_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tgt_dir_q <= COAST;
        tgt_spd_q <= '0;
        cur_dir_q <= COAST;
        cur_spd_q <= '0;
      end else begin
        tgt_dir_q <= tgt_dir_d;
        tgt_spd_q <= tgt_spd_d;
        cur_dir_q <= cur_dir_d;
        cur_spd_q <= cur_spd_d;
      end
    end

    assign cur_dir_v[i] = cur_dir_q;
    assign cur_spd_v[i] = cur_spd_q;
    assign chg_v[i]     = (cur_dir_d != cur_dir_q) || (cur_spd_d != cur_spd_q);
    assign diff_v[i]    = (cur_dir_q != tgt_dir_q) || (cur_spd_q != tgt_spd_q);
  end

  assign b1 = {4'(ch_q), 2'b00, snap_dir_q};
  assign b2 = 8'(snap_spd_q) << (8 - SPEED_W);
  assign b3 = checksum(FRAME_HDR, b1, b2);

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pend_d      = pend_q;
    abort_d     = abort_q;
    snap_dir_d  = snap_dir_q;
    snap_spd_d  = snap_spd_q;
    burst_start = 1'b0;
    tx_start    = 1'b0;
    tx_data     = FRAME_HDR;
    burst_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (abort_q || pend_q || trig || estop_rise) begin
          state_d     = ST_LOAD;
          ch_d        = '0;
          burst_start = 1'b1;
          // The post-estop stop burst leaves any pending follow-up in place.
          if (abort_q) begin
            abort_d = 1'b0;
            if (trig) pend_d = 1'b1;
          end else begin
            pend_d = 1'b0;
          end
        end
      end
      ST_LOAD: begin
        snap_dir_d = motor_dir_t'(cur_dir_v[ch_q]);
        snap_spd_d = cur_spd_v[ch_q];
        tx_start   = 1'b1;
        tx_data    = FRAME_HDR;
        state_d    = ST_SEND_B0;
      end
      ST_SEND_B0: begin
        if (tx_done) begin
          if (abort_q) begin
            state_d = ST_IDLE;
          end else begin
            tx_start = 1'b1;
            tx_data  = b1;
            state_d  = ST_SEND_B1;
          end
        end
      end
      ST_SEND_B1: begin
        if (tx_done) begin
          if (abort_q) begin
            state_d = ST_IDLE;
          end else begin
            tx_start = 1'b1;
            tx_data  = b2;
            state_d  = ST_SEND_B2;
          end
        end
      end
      ST_SEND_B2: begin
        if (tx_done) begin
          if (abort_q) begin
            state_d = ST_IDLE;
          end else begin
            tx_start = 1'b1;
            tx_data  = b3;
            state_d  = ST_SEND_B3;
          end
        end
      end
      ST_SEND_B3: begin
        if (tx_done) state_d = abort_q ? ST_IDLE : ST_NEXT_CH;
      end
      ST_NEXT_CH: begin
        if (abort_q) begin
          state_d = ST_IDLE;
        end else if (ch_q == CHW'(NUM_MOTORS - 1)) begin
          state_d = ST_DONE;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        burst_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE) begin
      if (estop_rise) abort_d = 1'b1;
      if (trig)       pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      pend_q     <= 1'b0;
      abort_q    <= 1'b0;
      snap_dir_q <= COAST;
      snap_spd_q <= '0;
      ramp_q     <= '0;
      ref_q      <= '0;
      estop_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      pend_q     <= pend_d;
      abort_q    <= abort_d;
      snap_dir_q <= snap_dir_d;
      snap_spd_q <= snap_spd_d;
      ramp_q     <= ramp_d;
      ref_q      <= ref_d;
      estop_q    <= estop;
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (tx_data),
    .tx   (tx_line),
    .done (tx_done)
  );

  assign uart_out = tx_line;
  assign busy     = (state_q != ST_IDLE);

endmodule
